// File: rtl/cpu_tb_pkg.sv
// Shared encodings for the CPU checkpoint monitor.
// Status codes, finish reasons and FSM states.
package cpu_tb_pkg;

  localparam int WORD_SIZE_DEF = 16;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_PASS  = 2'b01;
  localparam logic [1:0] ST_WRONG = 2'b10;

  typedef enum logic [1:0] {
    FR_NONE    = 2'd0,
    FR_HALT    = 2'd1,
    FR_TIMEOUT = 2'd2,
    FR_FAIL    = 2'd3
  } reason_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/checkpoint_table.sv
// Checkpoint register file plus per-entry result status.
// Table contents survive reset; status does not.
module checkpoint_table
  import cpu_tb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_TEST  = 64,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 we,
  input  logic [IDX_W-1:0]     w_idx,
  input  logic [WORD_SIZE-1:0] w_num,
  input  logic [WORD_SIZE-1:0] w_ans,
  input  logic [WORD_SIZE-1:0] w_mask,
  input  logic [IDX_W-1:0]     p_idx,
  output logic [WORD_SIZE-1:0] p_num,
  output logic [WORD_SIZE-1:0] p_ans,
  output logic [WORD_SIZE-1:0] p_mask,
  input  logic                 fin_we,
  input  logic [IDX_W-1:0]     fin_idx,
  input  logic [1:0]           fin_st,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [1:0]           rd_status
);

  logic [WORD_SIZE-1:0] num_q  [NUM_TEST];
  logic [WORD_SIZE-1:0] ans_q  [NUM_TEST];
  logic [WORD_SIZE-1:0] mask_q [NUM_TEST];
  logic [1:0]           st_q   [NUM_TEST];

  always_ff @(posedge clk) begin
    if (we) begin
      num_q[w_idx]  <= w_num;
      ans_q[w_idx]  <= w_ans;
      mask_q[w_idx] <= w_mask;
    end
  end

  assign p_num  = num_q[p_idx];
  assign p_ans  = ans_q[p_idx];
  assign p_mask = mask_q[p_idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      if (!reset_n || clr)
        st_q[i] <= ST_NONE;
      else if (fin_we && fin_idx == IDX_W'(i))
        st_q[i] <= fin_st;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rd_status <= ST_NONE;
    else
      rd_status <= st_q[rd_idx];
  end

endmodule

// File: rtl/cpu_checkpoint_monitor.sv
// Run-time scoreboard comparing CPU output_port against a
// table of (instruction count, expected value, mask) checkpoints.
module cpu_checkpoint_monitor
  import cpu_tb_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int NUM_TEST   = 64,
  parameter int IDX_W      = 6,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 30000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [WORD_SIZE-1:0] cfg_num_inst,
  input  logic [WORD_SIZE-1:0] cfg_ans,
  input  logic [WORD_SIZE-1:0] cfg_mask,
  input  logic [IDX_W:0]       cfg_count,
  input  logic                 stop_on_fail,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           finish_reason,
  output logic                 all_pass,
  output logic [IDX_W:0]       pass_count,
  output logic [IDX_W:0]       fail_count,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_val,
  output logic [CYC_W-1:0]     cycle_count,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [1:0]           rd_status
);

  state_t               state;
  logic [IDX_W:0]       ptr;
  logic [IDX_W:0]       count_l;
  logic                 stop_l;
  logic                 cur_seen;
  logic                 cur_wrong;
  logic                 ff_valid;
  logic [WORD_SIZE-1:0] e_num;
  logic [WORD_SIZE-1:0] e_ans;
  logic [WORD_SIZE-1:0] e_mask;

  logic           in_run;
  logic           active;
  logic           hit;
  logic           mism;
  logic           past;
  logic           seen_now;
  logic           wrong_now;
  logic           fail_stop;
  logic           timeout;
  logic           end_run;
  logic           fin;
  logic [1:0]     fin_st;
  logic [IDX_W:0] pass_nx;
  logic [IDX_W:0] fail_nx;
  logic           clr;
  logic           tbl_we;

  checkpoint_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .we        (tbl_we),
    .w_idx     (cfg_idx),
    .w_num     (cfg_num_inst),
    .w_ans     (cfg_ans),
    .w_mask    (cfg_mask),
    .p_idx     (ptr[IDX_W-1:0]),
    .p_num     (e_num),
    .p_ans     (e_ans),
    .p_mask    (e_mask),
    .fin_we    (fin),
    .fin_idx   (ptr[IDX_W-1:0]),
    .fin_st    (fin_st),
    .rd_idx    (rd_idx),
    .rd_status (rd_status)
  );

  always_comb begin
    in_run    = (state == S_RUN);
    active    = in_run && (ptr < count_l);
    hit       = active && (num_inst == e_num);
    mism      = hit && (((output_port ^ e_ans) & e_mask) != '0);
    past      = active && (num_inst > e_num);
    seen_now  = cur_seen | hit;
    wrong_now = cur_wrong | mism;
    fail_stop = stop_l && mism;
    timeout   = (cycle_count == CYC_W'(MAX_CYCLES - 1));
    end_run   = in_run && (fail_stop || is_halted || timeout);
    // the entry under ptr retires on overshoot or when the run ends
    fin       = active && (past || end_run);
    fin_st    = wrong_now ? ST_WRONG :
                seen_now  ? ST_PASS  : ST_NONE;
    pass_nx   = pass_count
              + (IDX_W+1)'(fin && fin_st == ST_PASS);
    fail_nx   = fail_count
              + (IDX_W+1)'(fin && fin_st == ST_WRONG);
    clr       = start && (state != S_RUN);
    tbl_we    = cfg_we && (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      finish_reason  <= FR_NONE;
      all_pass       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
      cycle_count    <= '0;
      ptr            <= '0;
      count_l        <= '0;
      stop_l         <= 1'b0;
      cur_seen       <= 1'b0;
      cur_wrong      <= 1'b0;
      ff_valid       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            finish_reason  <= FR_NONE;
            all_pass       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            cycle_count    <= '0;
            ptr            <= '0;
            count_l        <= cfg_count;
            stop_l         <= stop_on_fail;
            cur_seen       <= 1'b0;
            cur_wrong      <= 1'b0;
            ff_valid       <= 1'b0;
          end
        end
        S_RUN: begin
          pass_count <= pass_nx;
          fail_count <= fail_nx;
          if (mism && !ff_valid) begin
            ff_valid       <= 1'b1;
            first_fail_idx <= ptr[IDX_W-1:0];
            first_fail_val <= output_port;
          end
          if (fin) begin
            cur_seen  <= 1'b0;
            cur_wrong <= 1'b0;
          end else begin
            cur_seen  <= seen_now;
            cur_wrong <= wrong_now;
          end
          if (end_run) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= (pass_nx == count_l);
            finish_reason <= fail_stop ? FR_FAIL :
                             is_halted ? FR_HALT : FR_TIMEOUT;
          end else begin
            cycle_count <= cycle_count + CYC_W'(1);
            if (past)
              ptr <= ptr + (IDX_W+1)'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_checkpoint_monitor.sv
// Scoreboard bench for cpu_checkpoint_monitor.
// Expected run results are queued with stimulus, popped at done.
module tb_cpu_checkpoint_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [5:0]  cfg_idx;
  logic [15:0] cfg_num_inst;
  logic [15:0] cfg_ans;
  logic [15:0] cfg_mask;
  logic [6:0]  cfg_count;
  logic        stop_on_fail;
  logic        start;
  logic [15:0] num_inst;
  logic [15:0] output_port;
  logic        is_halted;
  logic        busy;
  logic        done;
  logic [1:0]  finish_reason;
  logic        all_pass;
  logic [6:0]  pass_count;
  logic [6:0]  fail_count;
  logic [5:0]  first_fail_idx;
  logic [15:0] first_fail_val;
  logic [15:0] cycle_count;
  logic [5:0]  rd_idx;
  logic [1:0]  rd_status;

  cpu_checkpoint_monitor dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_num_inst   (cfg_num_inst),
    .cfg_ans        (cfg_ans),
    .cfg_mask       (cfg_mask),
    .cfg_count      (cfg_count),
    .stop_on_fail   (stop_on_fail),
    .start          (start),
    .num_inst       (num_inst),
    .output_port    (output_port),
    .is_halted      (is_halted),
    .busy           (busy),
    .done           (done),
    .finish_reason  (finish_reason),
    .all_pass       (all_pass),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_val (first_fail_val),
    .cycle_count    (cycle_count),
    .rd_idx         (rd_idx),
    .rd_status      (rd_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int o;
    bit h;
  } stim_t;

  typedef struct {
    int reason;
    int pass;
    int fail;
    int ap;
    int cyc;
    int ffidx;
    int ffval;
  } exp_t;

  stim_t sq[$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int n, input int o, input bit h);
    sq.push_back('{n: n, o: o, h: h});
  endtask

  task automatic ramp(input int a, input int b);
    for (int i = a; i <= b; i++) push(i, 0, 1'b0);
  endtask

  task automatic expect_run(input int reason, input int pass,
                            input int fail, input int ap,
                            input int cyc, input int ffidx,
                            input int ffval);
    sb.push_back('{reason, pass, fail, ap, cyc, ffidx, ffval});
  endtask

  task automatic wr(input int idx, input int n, input int ans,
                    input int mask);
    @(negedge clk);
    cfg_we       = 1'b1;
    cfg_idx      = 6'(idx);
    cfg_num_inst = 16'(n);
    cfg_ans      = 16'(ans);
    cfg_mask     = 16'(mask);
    @(negedge clk);
    cfg_we       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".reason"}, finish_reason, 0);
    check({tag, ".pass"}, pass_count, 0);
    check({tag, ".fail"}, fail_count, 0);
    check({tag, ".cyc"}, cycle_count, 0);
    check({tag, ".ap"}, all_pass, 0);
    check({tag, ".ffidx"}, first_fail_idx, 0);
    check({tag, ".ffval"}, first_fail_val, 0);
  endtask

  task automatic rd_chk(input string tag, input int idx,
                        input int exp);
    @(negedge clk);
    rd_idx = 6'(idx);
    @(negedge clk);
    check(tag, rd_status, exp);
  endtask

  task automatic go(input string tag, input bit stop,
                    input int cnt, input int budget);
    exp_t e;
    int   k;
    @(negedge clk);
    cfg_count    = 7'(cnt);
    stop_on_fail = stop;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    while (sq.size() > 0) begin
      stim_t s;
      s = sq.pop_front();
      num_inst    = 16'(s.n);
      output_port = 16'(s.o);
      is_halted   = s.h;
      @(negedge clk);
    end
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".done"}, done, 1);
    e = sb.pop_front();
    check({tag, ".reason"}, finish_reason, e.reason);
    check({tag, ".pass"}, pass_count, e.pass);
    check({tag, ".fail"}, fail_count, e.fail);
    check({tag, ".ap"}, all_pass, e.ap);
    check({tag, ".cyc"}, cycle_count, e.cyc);
    check({tag, ".ffidx"}, first_fail_idx, e.ffidx);
    check({tag, ".ffval"}, first_fail_val, e.ffval);
    check({tag, ".busy_end"}, busy, 0);
  endtask

  task automatic stream_basic(input int v11);
    ramp(0, 10);
    push(11, v11, 1'b0);
    push(12, v11, 1'b1);
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_we       = 1'b0;
    cfg_idx      = '0;
    cfg_num_inst = '0;
    cfg_ans      = '0;
    cfg_mask     = '0;
    cfg_count    = '0;
    stop_on_fail = 1'b0;
    start        = 1'b0;
    num_inst     = '0;
    output_port  = '0;
    is_halted    = 1'b0;
    rd_idx       = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("rst");
    check("rst.rd", rd_status, 0);

    wr(0, 3, 16'h0000, 16'hFFFF);
    wr(1, 5, 16'h0000, 16'hFFFF);
    wr(2, 11, 16'h0001, 16'hFFFF);

    stream_basic(1);
    expect_run(1, 3, 0, 1, 12, 0, 0);
    go("halt", 1'b0, 3, 50);
    rd_chk("halt.rd2", 2, 1);

    stream_basic(2);
    expect_run(3, 2, 1, 0, 11, 2, 2);
    go("fstop", 1'b1, 3, 50);
    rd_chk("fstop.rd2", 2, 2);

    stream_basic(2);
    expect_run(1, 2, 1, 0, 12, 2, 2);
    go("cont", 1'b0, 3, 50);
    rd_chk("cont.rd2", 2, 2);
    rd_chk("cont.rd0", 0, 1);

    do_reset();
    wr(0, 7, 16'hFFFE, 16'h00FF);
    wr(1, 9, 16'h1234, 16'hFFFF);
    ramp(0, 6);
    push(7, 16'h12FE, 1'b0);
    push(8, 0, 1'b0);
    repeat (3) push(10, 0, 1'b0);
    push(11, 0, 1'b1);
    expect_run(1, 1, 0, 0, 12, 0, 0);
    go("mask", 1'b0, 2, 50);
    rd_chk("mask.rd0", 0, 1);
    rd_chk("mask.rd1", 1, 0);

    do_reset();
    wr(0, 3, 16'h0000, 16'hFFFF);
    wr(1, 5, 16'h0000, 16'hFFFF);
    ramp(0, 20);
    expect_run(2, 2, 0, 1, 29999, 0, 0);
    go("tmo", 1'b0, 2, 40000);

    // abort a run with a reset after a write attempt while busy
    @(negedge clk);
    cfg_count    = 7'd3;
    stop_on_fail = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      num_inst    = 16'(i);
      output_port = '0;
      is_halted   = 1'b0;
      cfg_we      = (i == 2);
      cfg_idx     = 6'd2;
      cfg_num_inst = 16'd11;
      cfg_ans     = 16'h0005;
      cfg_mask    = 16'hFFFF;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    check("abort.pass_mid", pass_count, 1);
    do_reset();
    check_idle("abort");
    rd_chk("abort.rd0", 0, 0);

    stream_basic(1);
    expect_run(1, 3, 0, 1, 12, 0, 0);
    go("rerun", 1'b0, 3, 50);

    push(0, 0, 1'b1);
    expect_run(1, 0, 0, 1, 0, 0, 0);
    go("cnt0", 1'b0, 0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_checkpoint_monitor.md
Name: cpu_checkpoint_monitor

Overview:
- Synthesizable run-time checker for the 16-bit pipelined/cached CPU. It compares `output_port` against a loadable table of (instruction count, expected value, mask) checkpoints while the core executes.
- Tracks pass/wrong/no-result per checkpoint, counts cycles, and detects halt and timeout.
- Sits beside the `cpu` instance on FPGA and in regression benches; replaces hard-coded bench tables with a configurable, multi-mode hardware scoreboard.

Parameters:
- WORD_SIZE, 16, width of `num_inst`, `output_port`, expected values and masks.
- NUM_TEST, 64, checkpoint table depth.
- IDX_W, 6, index width; must satisfy 2**IDX_W >= NUM_TEST.
- CYC_W, 16, cycle-counter width.
- MAX_CYCLES, 30000, timeout limit in RUN cycles.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- cfg_we  in  1  write one table entry (accepted only in IDLE).
- cfg_idx  in  IDX_W  entry index.
- cfg_num_inst  in  WORD_SIZE  instruction count at which to check.
- cfg_ans  in  WORD_SIZE  expected `output_port`.
- cfg_mask  in  WORD_SIZE  compare mask (1 = bit checked).
- cfg_count  in  IDX_W+1  number of valid entries, sampled on `start`.
- stop_on_fail  in  1  mode, sampled on `start`: 1 = finish at first wrong; 0 = continue.
- start  in  1  pulse; begins a run.
- num_inst  in  WORD_SIZE  CPU retired-instruction count.
- output_port  in  WORD_SIZE  CPU WWD output.
- is_halted  in  1  CPU halt flag.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- finish_reason  out  2  0 none, 1 halt, 2 timeout, 3 fail-stop.
- all_pass  out  1  `done` and `pass_count == count`.
- pass_count  out  IDX_W+1  entries finalized pass.
- fail_count  out  IDX_W+1  entries finalized wrong.
- first_fail_idx  out  IDX_W  index of first wrong entry.
- first_fail_val  out  WORD_SIZE  `output_port` at first mismatch.
- cycle_count  out  CYC_W  RUN cycles elapsed.
- rd_idx  in  IDX_W  status readback index.
- rd_status  out  2  registered status of `rd_idx`: 00 no result, 01 pass, 10 wrong; 1-cycle latency.

Behaviour:
- Reset sets state to IDLE and zeroes all outputs, counters and status entries. The table contents are left unchanged.
- State machine:
  - IDLE → RUN on `start`. Entering RUN clears counters, `first_fail_*` and all statuses, sets `ptr = 0`, and latches `cfg_count` and `stop_on_fail`.
  - RUN → DONE on the first of the following, in priority order: fail-stop, `is_halted`, `cycle_count == MAX_CYCLES - 1`.
  - DONE → RUN on `start` (restart with the same clearing). DONE otherwise holds.
  - `cfg_we` in RUN or DONE is ignored.
- Table entries must be sorted ascending by `num_inst`. `num_inst` advances by at most 1 per cycle.
- Each RUN cycle, with `ptr < count` and `e = table[ptr]`:
  - If `num_inst == e.num_inst`: compare `(output_port & e.mask)` with `(e.ans & e.mask)`. Set `seen[ptr]`. A mismatch sets the entry's sticky wrong bit; the first mismatch of the run captures `first_fail_idx`/`first_fail_val`.
  - If `num_inst > e.num_inst`: finalize the entry and advance `ptr` by 1. Finalize means wrong → `fail_count++`; else seen → pass, `pass_count++`; else no result.
  - Only one finalization per cycle.
- Fail-stop: with `stop_on_fail = 1`, the cycle of the first mismatch finalizes that entry wrong and enters DONE next edge with reason 3.
- Entering DONE: the current entry at `ptr` is finalized using its state including the same-cycle compare. Example: halt and match in the same cycle counts as pass. Remaining entries stay no result.
- `cycle_count` increments every RUN cycle and is frozen in DONE.
- `count = 0`: no checks are made; `all_pass = 1` when `done`.
- Mid-run reset aborts to IDLE; status is cleared.
- All outputs are registered.

Decomposition:
- Shared package `cpu_tb_pkg`:
  - status encodings (`ST_NONE`, `ST_PASS`, `ST_WRONG`),
  - finish-reason codes,
  - FSM state encoding,
  - default WORD_SIZE.
- One sub-module, `checkpoint_table`: the NUM_TEST-entry register file with a write port and two read ports (`ptr`, `rd_idx`) plus the per-entry status array.

Test Plan:
- Table {(3,0x0000),(5,0x0000),(11,0x0001)}, count=3; drive a matching stream then `is_halted` at num_inst 12 → `done`, reason 1, pass_count=3, all_pass=1.
- Same table with `output_port = 0x0002` at num_inst 11, stop_on_fail=1 → DONE next cycle, reason 3, first_fail_idx=2, first_fail_val=0x0002, fail_count=1, pass_count=2.
- Same mismatch with stop_on_fail=0 → run continues to halt, fail_count=1, all_pass=0, rd_status(2)=10.
- Entry (7,0xFFFE) with mask 0x00FF and `output_port = 0x12FE` → pass. Entry (9,…) where `num_inst` jumps from 8 to 10 across held cycles → rd_status=00.
- No halt with count=2 → `done` after MAX_CYCLES cycles, reason 2, cycle_count=29999.
- Reset asserted mid-RUN then `start` → counters zero, ptr restarts, results match a fresh run; `cfg_we` during RUN does not alter the table.
